i2c_bus_arbiter: RTL and testbench
==================================

// Module: i2c_bus_arbiter
// PURPOSE
//  Shares the single I2C master engine (driving i2c_scl_io/i2c_sda_io) between NUM_REQ
//  requesters inside the soc (MCU peripheral bridge, codec init sequencer, MIDI-driven
//  control writers). Round-robin arbitration; grant locked for one complete master
//  transaction. Optional watchdog aborts a hung transaction.
// PARAMETERS
//  NUM_REQ        4          number of requesters, 2..8
//  DATA_W         8          read/write data width
//  TIMEOUT_CYCLES 1_000_000  watchdog limit in clk_i cycles (WAIT state only)
// PORTS
//  clk_i      in   1                 system clock; one clock domain
//  rst_ni     in   1                 reset, synchronous, active-low
//  req_i      in   NUM_REQ           per-requester request level
//  cmd_i      in   NUM_REQ x i2c_cmd_t  per-requester command, packed array
//  gnt_o      out  NUM_REQ           one-hot grant; all-zero when no grant
//  done_o     out  NUM_REQ           one-cycle completion pulse to the owner
//  err_o      out  1                 NACK/timeout status of last completed transaction
//  rdata_o    out  DATA_W            read data of last completed transaction, broadcast
//  m_start_o  out  1                 one-cycle start strobe to the master engine
//  m_cmd_o    out  i2c_cmd_t         command to the master; valid while m_start_o=1
//  m_abort_o  out  1                 one-cycle abort strobe to the master
//  m_busy_i   in   1                 master engine busy
//  m_done_i   in   1                 master completion pulse
//  m_nack_i   in   1                 NACK flag; qualified by m_done_i
//  m_rdata_i  in   DATA_W            read data; qualified by m_done_i
//  timeout_o  out  1                 one-cycle watchdog-fired pulse
// BEHAVIOUR
//  - Reset: state IDLE, gnt_o=0, done_o=0, err_o=0, rdata_o=0, m_start_o=0, m_abort_o=0,
//    timeout_o=0, m_cmd_o=0, rr pointer=0 (req 0 highest priority first). Applies mid-transaction.
//  - FSM: IDLE -> ISSUE -> WAIT -> RELEASE -> IDLE.
//  - IDLE: if |req_i && !m_busy_i at edge T: pick the first set req starting at index ptr,
//    wrapping modulo NUM_REQ. Register idx and gnt_o=1<<idx, then go to ISSUE. If m_busy_i=1,
//    stay in IDLE with no grant.
//  - ISSUE (cycle T+1): m_start_o=1, m_cmd_o=cmd_i[idx]; the command is captured in a
//    register at edge T and is stable for the whole transaction. Next state is WAIT.
//  - WAIT: hold gnt_o. On m_done_i: rdata_o<=m_rdata_i, err_o<=m_nack_i, done_o[idx]<=1;
//    go to RELEASE.
//  - RELEASE: done_o pulse is high for this single cycle; gnt_o=0; ptr<=idx+1 (wraps
//    NUM_REQ-1 -> 0); go to IDLE. The owner drops req_i during RELEASE. If req_i is still
//    high, it counts as a new request and competes normally.
//  - Dropping req_i after grant has no effect: the transaction completes and done_o still
//    pulses.
//  - Minimum latency: req_i sampled -> m_start_o is 1 cycle. m_done_i -> done_o is 1 cycle.
//    Back-to-back turnaround is 4 cycles + master time.
//  - m_done_i outside WAIT is ignored.
//  - err_o and rdata_o hold their values until the next completion.
// CONFIGURATION
//  I2C_ARB_TIMEOUT_EN defined:
//  - A 32-bit counter clears on WAIT entry and increments each WAIT cycle.
//  - If the counter reaches TIMEOUT_CYCLES-1 with m_done_i=0: m_abort_o=1 and timeout_o=1
//    for one cycle; err_o<=1, rdata_o unchanged, done_o[idx] pulses; go to RELEASE.
//  - If m_done_i coincides with expiry, normal completion wins and no abort is issued.
//  I2C_ARB_TIMEOUT_EN undefined: WAIT has no limit; m_abort_o and timeout_o are tied to 0;
//  no counter is built.
// STRUCTURE
//  - i2c_arb_pkg:
//    - i2c_cmd_t packed struct: rw (1), dev_addr (7), reg_addr (8), wdata (DATA_W), nbytes (2).
//    - arb_state_e enum: IDLE, ISSUE, WAIT, RELEASE.
//    - TIMEOUT_W = 32.
//  - One sub-module, rr_pick: combinational round-robin select.
//    Inputs: req vector, ptr. Outputs: idx, valid.
// TESTING
//  1 Reset, then req_i=4'b0001, m_busy_i=0 -> gnt_o=0001 and m_start_o=1 one cycle later;
//    m_done_i with m_rdata_i=8'hA5 -> done_o=0001 next cycle and rdata_o=A5.
//  2 req_i=4'b1111 held continuously -> grant order 0,1,2,3,0; each done_o pulse is exactly
//    one cycle; gnt_o is never multi-hot.
//  3 req_i=4'b0100 while m_busy_i=1 for 10 cycles -> no grant during those cycles;
//    gnt_o=0100 one cycle after m_busy_i falls.
//  4 Complete a transaction with m_nack_i=1 -> err_o=1; the next clean completion clears err_o.
//  5 With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no m_done_i -> m_abort_o, timeout_o and
//    done_o pulse 16 cycles after WAIT entry. With m_done_i at the expiry cycle -> no abort.
//  6 Assert rst_ni=0 during WAIT -> all outputs 0 at the next edge; after release, req 0
//    wins over a simultaneous req 3.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : i2c_arb_pkg
// Description : Shared types for the I2C bus arbiter: master command struct,
//               arbiter FSM state encoding and watchdog counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

  // Width of the write-data field carried inside a master command
  localparam int unsigned I2C_DATA_W = 8;

  // Watchdog counter width
  localparam int unsigned TIMEOUT_W = 32;

  // Command handed to the I2C master engine
  typedef struct packed {
    logic                  rw;
    logic [6:0]            dev_addr;
    logic [7:0]            reg_addr;
    logic [I2C_DATA_W-1:0] wdata;
    logic [1:0]            nbytes;
  } i2c_cmd_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request at or after i_ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  int unsigned w_j;

  // Scan from the farthest offset down to offset 0 so the nearest request
  // after the pointer is the last (winning) assignment.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= NUM_REQ) begin
        w_j = w_j - NUM_REQ;
      end
      if (i_req[w_j[IDX_W-1:0]]) begin
        o_idx   = w_j[IDX_W-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_arbiter
// Description : Shares one I2C master engine between NUM_REQ requesters.
//               Round-robin arbitration, grant held for one complete master
//               transaction (IDLE -> ISSUE -> WAIT -> RELEASE).
//               Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN:
//               aborts a transaction that stays in WAIT for TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  i2c_cmd_t [NUM_REQ-1:0] cmd_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic                   err_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   m_start_o,
  output i2c_cmd_t               m_cmd_o,
  output logic                   m_abort_o,
  input  logic                   m_busy_i,
  input  logic                   m_done_i,
  input  logic                   m_nack_i,
  input  logic [DATA_W-1:0]      m_rdata_i,
  output logic                   timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  i2c_cmd_t           r_cmd;
  logic               r_err;
  logic [DATA_W-1:0]  r_rdata;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_grant;
  logic               w_complete;
  logic               w_expire;
  logic               w_wd_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state event strobes
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_complete  = 1'b0;
    w_expire    = 1'b0;
    m_start_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid && !m_busy_i) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_start_o   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A completion arriving on the expiry cycle takes priority
        if (m_done_i) begin
          w_complete  = 1'b1;
          w_state_nxt = RELEASE;
        end else if (w_wd_hit) begin
          w_expire    = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Grant, command capture, completion status and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_idx   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_cmd   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= '0;
      if (w_grant) begin
        r_idx <= w_pick_idx;
        r_gnt <= NUM_REQ'(1) << w_pick_idx;
        r_cmd <= cmd_i[w_pick_idx];
      end
      if (w_complete || w_expire) begin
        r_gnt  <= '0;
        r_done <= NUM_REQ'(1) << r_idx;
        r_err  <= w_complete ? m_nack_i : 1'b1;
      end
      if (w_complete) begin
        r_rdata <= m_rdata_i;
      end
      if (r_state == RELEASE) begin
        r_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wd_cnt;
  logic                 r_expire;

  // Watchdog: cleared while issuing (i.e. on WAIT entry), counts WAIT cycles;
  // the expiry strobe is registered so abort/timeout line up with done_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wd_cnt <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= w_expire;
      if (r_state == ISSUE) begin
        r_wd_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
    end
  end

  assign w_wd_hit  = (r_wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign m_abort_o = r_expire;
  assign timeout_o = r_expire;
`else
  assign w_wd_hit  = 1'b0;
  assign m_abort_o = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign gnt_o   = r_gnt;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;
  assign m_cmd_o = r_cmd;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_bus_arbiter
// Description : Self-checking bench for i2c_bus_arbiter. Expected completions
//               are queued when a transaction is granted and compared when
//               done_o pulses. Watchdog scenarios follow I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 1_000_000;
`endif

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [NUM_REQ-1:0]     req_i;
  i2c_cmd_t [NUM_REQ-1:0] cmd_v;
  logic [NUM_REQ-1:0]     gnt_o;
  logic [NUM_REQ-1:0]     done_o;
  logic                   err_o;
  logic [DATA_W-1:0]      rdata_o;
  logic                   m_start_o;
  i2c_cmd_t               m_cmd_o;
  logic                   m_abort_o;
  logic                   m_busy_i;
  logic                   m_done_i;
  logic                   m_nack_i;
  logic [DATA_W-1:0]      m_rdata_i;
  logic                   timeout_o;

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .cmd_i     (cmd_v),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .m_start_o (m_start_o),
    .m_cmd_o   (m_cmd_o),
    .m_abort_o (m_abort_o),
    .m_busy_i  (m_busy_i),
    .m_done_i  (m_done_i),
    .m_nack_i  (m_nack_i),
    .m_rdata_i (m_rdata_i),
    .timeout_o (timeout_o)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    step();
    step();
    rst_ni = 1'b1;
    sb.delete();
  endtask

  // Bounded wait for the start strobe; ok=0 when the budget runs out
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      step();
      if (m_start_o === 1'b1) ok = 1'b1;
    end
  endtask

  // Master engine completion pulse, one cycle wide
  task automatic pulse_done(input logic [7:0] rd, input logic nack);
    m_rdata_i = rd;
    m_nack_i  = nack;
    m_done_i  = 1'b1;
    step();
    m_done_i  = 1'b0;
    m_nack_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    step();
    step();
    checks++;
    if ({gnt_o, done_o, err_o, rdata_o, m_start_o, m_abort_o, timeout_o} !== '0 || m_cmd_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdata=%h start=%b abort=%b tmo=%b cmd=%h, want all zero",
               gnt_o, done_o, err_o, rdata_o, m_start_o, m_abort_o, timeout_o, m_cmd_o);
    end
    rst_ni = 1'b1;
    sb.delete();
  endtask

  task automatic test_basic();
    exp_t e;
    logic [3:0] ed;
    req_i = 4'b0001;
    step();
    checks++;
    if (gnt_o !== 4'b0001 || m_start_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_grant_latency: gnt=%b start=%b, want 0001/1", gnt_o, m_start_o);
    end
    checks++;
    if (m_cmd_o !== cmd_v[0]) begin
      failures++;
      $display("FAIL basic_cmd: got %h want %h", m_cmd_o, cmd_v[0]);
    end
    sb.push_back('{idx: 0, rdata: 8'hA5, err: 1'b0});
    req_i = '0;
    step();
    pulse_done(8'hA5, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({done_o, rdata_o, err_o, gnt_o} !== {ed, e.rdata, e.err, 4'b0000}) begin
      failures++;
      $display("FAIL basic_complete: done=%b rdata=%h err=%b gnt=%b, want %b/%h/%b/0000",
               done_o, rdata_o, err_o, gnt_o, ed, e.rdata, e.err);
    end
    step();
    checks++;
    if (done_o !== 4'b0000) begin
      failures++;
      $display("FAIL basic_done_width: done=%b want 0000", done_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    exp_t e;
    logic [3:0] ed;
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_start_timeout: iteration %0d got no m_start_o", k);
      end
      ed = 4'(1) << (k % 4);
      checks++;
      if (gnt_o !== ed || m_cmd_o !== cmd_v[k % 4]) begin
        failures++;
        $display("FAIL rr_order: iter %0d gnt=%b cmd=%h want %b/%h", k, gnt_o, m_cmd_o, ed, cmd_v[k % 4]);
      end
      if (k == 4) req_i = '0;
      sb.push_back('{idx: k % 4, rdata: 8'(8'h10 + k), err: 1'b0});
      step();
      pulse_done(8'(8'h10 + k), 1'b0);
      e  = sb.pop_front();
      ed = 4'(1) << e.idx;
      checks++;
      if ({done_o, rdata_o, err_o} !== {ed, e.rdata, e.err}) begin
        failures++;
        $display("FAIL rr_complete: iter %0d done=%b rdata=%h err=%b want %b/%h/%b",
                 k, done_o, rdata_o, err_o, ed, e.rdata, e.err);
      end
      step();
      checks++;
      if (done_o !== 4'b0000 || gnt_o !== 4'b0000) begin
        failures++;
        $display("FAIL rr_done_width: iter %0d done=%b gnt=%b want 0000/0000", k, done_o, gnt_o);
      end
    end
  endtask

  task automatic test_busy();
    exp_t e;
    logic [3:0] ed;
    bit bad;
    bad      = 1'b0;
    m_busy_i = 1'b1;
    req_i    = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      if (gnt_o !== 4'b0000 || m_start_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL busy_no_grant: grant seen while busy (gnt=%b), want none", gnt_o);
    end
    m_busy_i = 1'b0;
    step();
    checks++;
    if (gnt_o !== 4'b0100 || m_start_o !== 1'b1) begin
      failures++;
      $display("FAIL busy_release_grant: gnt=%b start=%b want 0100/1", gnt_o, m_start_o);
    end
    sb.push_back('{idx: 2, rdata: 8'h77, err: 1'b0});
    req_i = '0;
    step();
    pulse_done(8'h77, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({done_o, rdata_o, err_o} !== {ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL busy_complete: done=%b rdata=%h err=%b want %b/%h/%b",
               done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
  endtask

  task automatic test_nack();
    bit ok;
    exp_t e;
    logic [3:0] ed;
    req_i = 4'b0010;
    wait_start(ok);
    checks++;
    if (!ok || gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL nack_grant: ok=%b gnt=%b want 1/0010", ok, gnt_o);
    end
    req_i = '0;
    sb.push_back('{idx: 1, rdata: 8'h3C, err: 1'b1});
    step();
    pulse_done(8'h3C, 1'b1);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({done_o, rdata_o, err_o} !== {ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL nack_complete: done=%b rdata=%h err=%b want %b/%h/%b",
               done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
    step();
    // Completion pulse from the master while idle must be ignored
    pulse_done(8'hEE, 1'b0);
    checks++;
    if (done_o !== 4'b0000 || err_o !== 1'b1 || rdata_o !== 8'h3C) begin
      failures++;
      $display("FAIL stray_done: done=%b err=%b rdata=%h want 0000/1/3c", done_o, err_o, rdata_o);
    end
    req_i = 4'b0010;
    wait_start(ok);
    req_i = '0;
    sb.push_back('{idx: 1, rdata: 8'h5A, err: 1'b0});
    step();
    pulse_done(8'h5A, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if (!ok || {done_o, rdata_o, err_o} !== {ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL nack_clear: ok=%b done=%b rdata=%h err=%b want 1/%b/%h/%b",
               ok, done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit bad;
    exp_t e;
    logic [3:0] ed;
    req_i = 4'b0001;
    wait_start(ok);
    req_i = '0;
    sb.push_back('{idx: 0, rdata: 8'h5A, err: 1'b1});
    bad = !ok;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (m_abort_o !== 1'b0 || timeout_o !== 1'b0 || done_o !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL wd_early: abort/timeout/done seen before expiry (ok=%b)", ok);
    end
    step();
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({m_abort_o, timeout_o, done_o, rdata_o, err_o} !== {2'b11, ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL wd_expire: abort=%b tmo=%b done=%b rdata=%h err=%b want 1/1/%b/%h/%b",
               m_abort_o, timeout_o, done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
    checks++;
    if (m_abort_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL wd_pulse_width: abort=%b tmo=%b want 0/0", m_abort_o, timeout_o);
    end
    req_i = 4'b0001;
    wait_start(ok);
    req_i = '0;
    sb.push_back('{idx: 0, rdata: 8'hC3, err: 1'b0});
    for (int k = 1; k <= 16; k++) step();
    pulse_done(8'hC3, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if (!ok || {m_abort_o, timeout_o, done_o, rdata_o, err_o} !== {2'b00, ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL wd_coincide: ok=%b abort=%b tmo=%b done=%b rdata=%h err=%b want 1/0/0/%b/%h/%b",
               ok, m_abort_o, timeout_o, done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
  endtask
`else
  task automatic test_timeout();
    bit ok;
    bit bad;
    exp_t e;
    logic [3:0] ed;
    req_i = 4'b0001;
    wait_start(ok);
    req_i = '0;
    sb.push_back('{idx: 0, rdata: 8'hC3, err: 1'b0});
    bad = !ok;
    for (int k = 0; k < 40; k++) begin
      step();
      if (m_abort_o !== 1'b0 || timeout_o !== 1'b0 || done_o !== 4'b0000 || gnt_o !== 4'b0001) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL no_wd_hold: long WAIT disturbed (gnt=%b abort=%b tmo=%b done=%b)",
               gnt_o, m_abort_o, timeout_o, done_o);
    end
    pulse_done(8'hC3, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({m_abort_o, timeout_o, done_o, rdata_o, err_o} !== {2'b00, ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL no_wd_complete: abort=%b tmo=%b done=%b rdata=%h err=%b want 0/0/%b/%h/%b",
               m_abort_o, timeout_o, done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    logic [3:0] ed;
    // Leaves the pointer at 1 so req 3 would win without a pointer reset
    req_i = 4'b0100;
    wait_start(ok);
    req_i = '0;
    step();
    step();
    rst_ni = 1'b0;
    step();
    sb.delete();
    checks++;
    if (!ok || {gnt_o, done_o, err_o, rdata_o, m_start_o, m_abort_o, timeout_o} !== '0 || m_cmd_o !== '0) begin
      failures++;
      $display("FAIL reset_mid: ok=%b gnt=%b done=%b err=%b rdata=%h start=%b abort=%b tmo=%b cmd=%h, want 1 then zeros",
               ok, gnt_o, done_o, err_o, rdata_o, m_start_o, m_abort_o, timeout_o, m_cmd_o);
    end
    rst_ni = 1'b1;
    req_i  = 4'b1001;
    step();
    checks++;
    if (gnt_o !== 4'b0001 || m_cmd_o !== cmd_v[0]) begin
      failures++;
      $display("FAIL reset_ptr: gnt=%b cmd=%h want 0001/%h", gnt_o, m_cmd_o, cmd_v[0]);
    end
    req_i = '0;
    sb.push_back('{idx: 0, rdata: 8'h11, err: 1'b0});
    step();
    pulse_done(8'h11, 1'b0);
    e  = sb.pop_front();
    ed = 4'(1) << e.idx;
    checks++;
    if ({done_o, rdata_o, err_o} !== {ed, e.rdata, e.err}) begin
      failures++;
      $display("FAIL reset_after_complete: done=%b rdata=%h err=%b want %b/%h/%b",
               done_o, rdata_o, err_o, ed, e.rdata, e.err);
    end
    step();
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_i     = '0;
    m_busy_i  = 1'b0;
    m_done_i  = 1'b0;
    m_nack_i  = 1'b0;
    m_rdata_i = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_v[i].rw       = i[0];
      cmd_v[i].dev_addr = 7'(8'h50 + i);
      cmd_v[i].reg_addr = 8'(8'h11 * (i + 1));
      cmd_v[i].wdata    = 8'(8'hC0 + i);
      cmd_v[i].nbytes   = 2'(i);
    end
    test_reset();
    test_basic();
    test_round_robin();
    test_busy();
    test_nack();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound for the whole run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire
